risc32_data_ram_arbiter: RTL and testbench

RISC32_DATA_RAM_ARBITER -- requirements
Module: risc32_data_ram_arbiter

---
 rtl/risc32_data_ram_arbiter.sv | 130 +++++++++++++
 tb/tb_risc32_data_ram_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/risc32_data_ram_arbiter.sv
// risc32_data_ram_arbiter: two-master arbiter in front of the data RAM.
// Optional round-robin arbitration under RISC32_DRAM_ARB_RR_EN.
module risc32_data_ram_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int MEM_WORDS = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [3:0]        m0_sel_i,
  input  logic [31:0]       m0_wdata_i,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  output logic [31:0]       m0_rdata_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [3:0]        m1_sel_i,
  input  logic [31:0]       m1_wdata_i,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic [31:0]       m1_rdata_o,
  output logic              ram_ce_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [3:0]        ram_sel_o,
  output logic [31:0]       ram_data_o,
  input  logic [31:0]       ram_data_i,
  output logic              busy_o,
  output logic              grant_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic [ADDR_W-2:0] WORDS = (ADDR_W-1)'(MEM_WORDS);

  logic [1:0]        state_q, state_d;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        sel_q;
  logic [31:0]       wdata_q;
  logic              grant_q;
  logic              err_q;
  logic [31:0]       rdata0_q;
  logic [31:0]       rdata1_q;

  logic              any_req;
  logic              win;
  logic [ADDR_W-2:0] widx;
  logic              oor;
  logic              in_acc;
  logic              ack_live;
  logic [31:0]       cap;

  // Pick the winner among the current requesters.
  always_comb begin
    any_req = m0_req_i | m1_req_i;
    win     = ~m0_req_i;
`ifdef RISC32_DRAM_ARB_RR_EN
    if (m0_req_i && m1_req_i) win = ~grant_q;
`endif
  end

  assign widx     = {1'b0, addr_q[ADDR_W-1:2]};
  assign oor      = (widx >= WORDS);
  assign in_acc   = (state_q == S_ACCESS);
  assign ack_live = (state_q == S_RESP) && !rst;
  assign cap      = (we_q || oor) ? 32'h0 : ram_data_i;

  // Sequence IDLE -> ACCESS -> RESP -> IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (any_req) state_d = S_ACCESS;
      S_ACCESS: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State, latched command and per-master response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      sel_q    <= 4'h0;
      wdata_q  <= 32'h0;
      grant_q  <= 1'b1;
      err_q    <= 1'b0;
      rdata0_q <= 32'h0;
      rdata1_q <= 32'h0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && any_req) begin
        grant_q <= win;
        we_q    <= win ? m1_we_i    : m0_we_i;
        addr_q  <= win ? m1_addr_i  : m0_addr_i;
        sel_q   <= win ? m1_sel_i   : m0_sel_i;
        wdata_q <= win ? m1_wdata_i : m0_wdata_i;
      end
      if (in_acc) begin
        err_q <= oor;
        if (grant_q) rdata1_q <= cap;
        else         rdata0_q <= cap;
      end
    end
  end

  assign ram_ce_o   = in_acc & ~oor;
  assign ram_we_o   = in_acc & ~oor & we_q;
  assign ram_addr_o = in_acc ? addr_q  : '0;
  assign ram_sel_o  = in_acc ? sel_q   : 4'h0;
  assign ram_data_o = in_acc ? wdata_q : 32'h0;

  assign m0_ack_o   = ack_live & ~grant_q;
  assign m1_ack_o   = ack_live &  grant_q;
  assign m0_err_o   = m0_ack_o & err_q;
  assign m1_err_o   = m1_ack_o & err_q;
  assign m0_rdata_o = rdata0_q;
  assign m1_rdata_o = rdata1_q;

  assign busy_o  = (state_q != S_IDLE);
  assign grant_o = grant_q;

endmodule

// File: tb/tb_risc32_data_ram_arbiter.sv
// tb_risc32_data_ram_arbiter: scoreboard bench with a behavioural RAM.
// Expected acks are queued at drive time and popped at each ack.
module tb_risc32_data_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_ce, ram_we;
  logic [31:0] ram_addr, ram_wd, ram_rd;
  logic [3:0]  ram_sel;
  logic        busy, grant;

  typedef struct packed {
    logic        m;
    logic [31:0] rd;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem [128];
  logic        load;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          acks    = 0;
  int          ce_cnt  = 0;

  always #5 clk = ~clk;

  risc32_data_ram_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr),
    .m0_sel_i(m0_sel), .m0_wdata_i(m0_wdata),
    .m0_ack_o(m0_ack), .m0_err_o(m0_err), .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr),
    .m1_sel_i(m1_sel), .m1_wdata_i(m1_wdata),
    .m1_ack_o(m1_ack), .m1_err_o(m1_err), .m1_rdata_o(m1_rdata),
    .ram_ce_o(ram_ce), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
    .ram_sel_o(ram_sel), .ram_data_o(ram_wd), .ram_data_i(ram_rd),
    .busy_o(busy), .grant_o(grant)
  );

  assign ram_rd = mem[ram_addr[8:2]];

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 128; i++) mem[i] <= 32'h5A5A0000 ^ i;
      mem[2] <= 32'hDEADBEEF;
      mem[4] <= 32'hAABBCCDD;
    end else if (ram_ce && ram_we) begin
      for (int b = 0; b < 4; b++)
        if (ram_sel[b]) mem[ram_addr[8:2]][8*b +: 8] <= ram_wd[8*b +: 8];
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (ram_ce) ce_cnt++;
    if (m0_ack || m1_ack) begin
      check("one_ack", {31'b0, m0_ack & m1_ack}, 0);
      check("ack_pending", {31'b0, sb.size() != 0}, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("ack_master", {31'b0, m1_ack}, {31'b0, e.m});
        check("rdata", m1_ack ? m1_rdata : m0_rdata, e.rd);
        check("err", {31'b0, m1_ack ? m1_err : m0_err}, {31'b0, e.err});
      end
      acks++;
    end
  end

  task automatic push(input logic m, input logic [31:0] rd,
                      input logic err);
    exp_t e;
    e.m = m; e.rd = rd; e.err = err;
    sb.push_back(e);
  endtask

  task automatic wait_acks(input int target, output int cyc);
    cyc = 0;
    while (acks < target && cyc < 50) begin
      @(negedge clk); #1;
      cyc++;
    end
    check("ack_timeout", {31'b0, acks >= target}, 1);
  endtask

  task automatic drive(input logic m, input logic req, input logic we,
                       input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] wd);
    if (m) begin
      m1_req = req; m1_we = we; m1_addr = a; m1_sel = s; m1_wdata = wd;
    end else begin
      m0_req = req; m0_we = we; m0_addr = a; m0_sel = s; m0_wdata = wd;
    end
  endtask

  task automatic access(input logic m, input logic we,
                        input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] wd, input logic [31:0] erd,
                        input logic eerr);
    int cyc;
    push(m, erd, eerr);
    @(negedge clk);
    drive(m, 1'b1, we, a, s, wd);
    wait_acks(acks + 1, cyc);
    check("latency", cyc, 2);
    drive(m, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  initial begin
    int c0, cyc;
    rst = 1'b1; load = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_grant", {31'b0, grant}, 1);
    check("rst_ce", {31'b0, ram_ce}, 0);
    check("rst_rdata0", m0_rdata, 0);
    rst = 1'b0; load = 1'b0;
    @(negedge clk);
    check("idle_busy", {31'b0, busy}, 0);
    check("idle_addr", ram_addr, 0);

    c0 = ce_cnt;
    access(1'b0, 1'b0, 32'h8, 4'hF, 32'h0, 32'hDEADBEEF, 1'b0);
    check("rd_ce_cycles", ce_cnt - c0, 1);
    check("grant_m0", {31'b0, grant}, 0);

    access(1'b1, 1'b1, 32'h10, 4'b0100, 32'h11223344, 32'h0, 1'b0);
    check("mem4_byte", mem[4], 32'hAA22CCDD);
    check("m0_hold", m0_rdata, 32'hDEADBEEF);
    check("grant_m1", {31'b0, grant}, 1);

    access(1'b0, 1'b0, 32'h10, 4'hF, 32'h0, 32'hAA22CCDD, 1'b0);

    c0 = ce_cnt;
    access(1'b0, 1'b0, 32'h200, 4'hF, 32'h0, 32'h0, 1'b1);
    check("oor_ce", ce_cnt - c0, 0);

    c0 = acks;
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 32'h8, 4'hF, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_no_ack", {31'b0, m1_ack}, 0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    check("rst_mid_busy", {31'b0, busy}, 0);
    check("rst_mid_grant", {31'b0, grant}, 1);
    check("rst_mid_rd0", m0_rdata, 0);
    check("rst_mid_rd1", m1_rdata, 0);
    check("rst_mid_ce", {31'b0, ram_ce}, 0);
    check("rst_mid_acks", acks - c0, 0);
    rst = 1'b0;
    access(1'b1, 1'b0, 32'h8, 4'hF, 32'h0, 32'hDEADBEEF, 1'b0);

    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
`ifdef RISC32_DRAM_ARB_RR_EN
    push(1'b0, 32'hDEADBEEF, 1'b0);
    push(1'b1, 32'hAA22CCDD, 1'b0);
    push(1'b0, 32'hDEADBEEF, 1'b0);
    push(1'b1, 32'hAA22CCDD, 1'b0);
`else
    for (int i = 0; i < 4; i++) push(1'b0, 32'hDEADBEEF, 1'b0);
`endif
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 32'h8, 4'hF, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
    wait_acks(acks + 4, cyc);
    check("contend_cycles", cyc, 11);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
`ifdef RISC32_DRAM_ARB_RR_EN
    check("m1_served", m1_rdata, 32'hAA22CCDD);
`else
    check("m1_starved", m1_rdata, 32'h0);
`endif
    repeat (4) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    check("end_busy", {31'b0, busy}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
